rr_mux_stream: RTL
==================

RR_MUX_STREAM -- requirements
Module: rr_mux_stream

Interface
REQ-001 SHALL have parameter N, default 4: number of input channels, legal range 1..16.
REQ-002 SHALL have parameter W, default 8: data width per channel, W >= 1.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  the single clock, all state on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  N  per-channel request; bit k belongs to channel k.
REQ-007 SHALL have port in_data  input  N*W  channel k data at bits [k*W +: W].
REQ-008 SHALL have port in_ready  output  N  per-channel accept; combinational, at most one bit high.
REQ-009 SHALL have port out_valid  output  1  registered output beat present.
REQ-010 SHALL have port out_data  output  W  registered selected data.
REQ-011 SHALL have port out_chan  output  CW  channel index of the beat in out_data, where CW = max(1, clog2(N)).
REQ-012 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-013 SHALL hold the output register in one of two states: EMPTY (out_valid=0) or FULL (out_valid=1).
REQ-014 SHALL assert load = !out_valid | out_ready, i.e. the register can take a new beat this cycle.
REQ-015 SHALL pick grant g as the first channel with in_valid high, searching ptr, ptr+1, ... N-1, 0, ... ptr-1 (wrap-around).
REQ-016 SHALL drive in_ready[g]=1 only when load=1 and any in_valid is high; all other in_ready bits SHALL be 0.
REQ-017 SHALL, on a cycle with in_valid[g] & in_ready[g], capture in_data[g] into out_data and g into out_chan, and set out_valid=1 on the next edge (1-cycle latency).
REQ-018 SHALL update ptr to (g+1) mod N on every capture and leave it unchanged otherwise.
REQ-019 SHALL clear out_valid on a cycle with out_valid & out_ready and no capture.
REQ-020 SHALL support a simultaneous drain and capture, giving a sustained throughput of 1 beat/cycle with no bubble.
REQ-021 SHALL hold out_data, out_chan and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, when no in_valid is high, drive in_ready=0 and leave ptr unchanged.
REQ-023 SHALL, with N=1, behave as a 1-deep registered pipeline stage with ptr constant 0 and out_chan=0.
REQ-024 SHALL not let in_ready depend on in_data; in_ready MAY depend combinationally on in_valid and out_ready.
REQ-025 SHALL require that upstream holds in_valid and in_data stable until accepted; the block does not check this.

Reset
REQ-026 SHALL, while rst_n=0, force out_valid=0, out_data=0, out_chan=0, ptr=0, and in_ready=0 asynchronously.
REQ-027 SHALL discard any beat held at the moment of reset; no partial beat is emitted after rst_n rises.
REQ-028 SHALL allow a capture on the first rising clk edge after rst_n is deasserted.

Configuration
REQ-029 SHALL compile in a per-channel inversion mode when macro RR_MUX_STREAM_INVERT_EN is defined.
REQ-030 SHALL, with RR_MUX_STREAM_INVERT_EN defined, add port inv  input  N, and capture in_data[g] XOR {W{inv[g]}}, sampled in the capture cycle.
REQ-031 SHALL, without RR_MUX_STREAM_INVERT_EN, omit port inv and capture in_data[g] unchanged.

Verification (N=4, W=8)
REQ-032 SHALL cover reset: with rst_n=0 mid-FULL holding 0xA5, require out_valid=0, out_data=0x00 and in_ready=0000 immediately; after release, require the first grant to go to channel 0.
REQ-033 SHALL cover fairness: with all in_valid=1111, data 0x10/0x11/0x12/0x13 and out_ready=1, require out_chan sequence 0,1,2,3,0 with matching data over 5 consecutive cycles, no bubbles.
REQ-034 SHALL cover backpressure: with out_ready=0 for 3 cycles while FULL with 0x11 on channel 1, require in_ready=0000 and out_data=0x11 held; when out_ready=1, require the next grant to go to channel 2.
REQ-035 SHALL cover sparse requests and wrap: with ptr=3 and only in_valid[1]=1 carrying 0x7E, require a grant to channel 1, out_chan=1, out_data=0x7E one cycle later, and ptr=2.
REQ-036 SHALL cover idle: with in_valid=0000 for 4 cycles after a drain, require out_valid=0 and ptr unchanged.
REQ-037 SHALL cover inversion (macro defined): with inv[2]=1 and in_data[2]=0x0F, require out_data=0xF0; with inv[2]=0, require out_data=0x0F.

Source files
------------

// File: rtl/rr_mux_stream.sv
// Round-robin N:1 stream multiplexer with a single registered output stage.
// Optional per-channel data inversion when RR_MUX_STREAM_INVERT_EN is defined.
module rr_mux_stream #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [CW-1:0]  out_chan,
  input  logic           out_ready
`ifdef RR_MUX_STREAM_INVERT_EN
  ,
  input  logic [N-1:0]   inv
`endif
);

  logic          r_valid;
  logic [W-1:0]  r_data;
  logic [CW-1:0] r_chan;
  logic [CW-1:0] r_ptr;

  logic          w_load;
  logic          w_found;
  int            w_gidx;
  logic [W-1:0]  w_sel;
  logic          w_capture;

  // Reset gates load so in_ready drops asynchronously along with the register.
  assign w_load    = rst_n & (~r_valid | out_ready);
  assign w_capture = w_load & w_found;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_gidx  = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(r_ptr) + i) % N;
      if (!w_found && in_valid[idx]) begin
        w_found = 1'b1;
        w_gidx  = idx;
      end
    end
  end

  always_comb begin
    w_sel    = '0;
    in_ready = '0;
    for (int k = 0; k < N; k++) begin
      if (w_gidx == k) begin
`ifdef RR_MUX_STREAM_INVERT_EN
        w_sel = in_data[k*W +: W] ^ {W{inv[k]}};
`else
        w_sel = in_data[k*W +: W];
`endif
        in_ready[k] = w_capture;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_ptr   <= '0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_data  <= w_sel;
      r_chan  <= CW'(w_gidx);
      r_ptr   <= CW'((w_gidx + 1) % N);
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_chan  = r_chan;

endmodule
